sb_color_sensor_ctrl: RTL and testbench

//  Parametrised TCS3200-style colour sensor controller. Drives filter selects s2/s3 through the sequence CLEAR, RED, GREEN, BLUE.

---
 rtl/sb_color_pkg.sv | 39 +++
 rtl/sb_edge_counter.sv | 41 ++++
 rtl/sb_color_sensor_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_sb_color_sensor_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/sb_color_pkg.sv
// Shared constants for the colour sensor controller: colour codes, filter
// indices with their s2/s3 encodings, and the scan FSM states.
package sb_color_pkg;

    localparam logic [2:0] COLOR_RED   = 3'b100;
    localparam logic [2:0] COLOR_GREEN = 3'b010;
    localparam logic [2:0] COLOR_BLUE  = 3'b001;
    localparam logic [2:0] COLOR_WHITE = 3'b111;
    localparam logic [2:0] COLOR_NONE  = 3'b000;

    localparam logic [1:0] F_CLEAR = 2'd0;
    localparam logic [1:0] F_RED   = 2'd1;
    localparam logic [1:0] F_GREEN = 2'd2;
    localparam logic [1:0] F_BLUE  = 2'd3;

    localparam logic [1:0] SEL_CLEAR = 2'b10;
    localparam logic [1:0] SEL_RED   = 2'b00;
    localparam logic [1:0] SEL_GREEN = 2'b11;
    localparam logic [1:0] SEL_BLUE  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_CLASSIFY,
        ST_UPDATE
    } state_e;

    // {s2, s3} for a filter index
    function automatic logic [1:0] filter_sel(input logic [1:0] f);
        case (f)
            F_RED:   filter_sel = SEL_RED;
            F_GREEN: filter_sel = SEL_GREEN;
            F_BLUE:  filter_sel = SEL_BLUE;
            default: filter_sel = SEL_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/sb_edge_counter.sv
// Synchronises the asynchronous sensor output, detects rising edges and
// counts them with saturation while enabled.
module sb_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             sig_async_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_nxt_o
);

    // [0],[1] synchroniser stages, [2] previous synchronised value
    logic [2:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise;

    assign rise = sync_q[1] & ~sync_q[2];

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && rise && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[1:0], sig_async_i};
            cnt_q  <= clr_i ? '0 : cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/sb_color_sensor_ctrl.sv
// TCS3200-style colour sensor controller: scans CLEAR/RED/GREEN/BLUE, classifies.
// Optional SB_COLOR_HYST_EN: publish only after HYST_N consecutive equal classes.
module sb_color_sensor_ctrl
    import sb_color_pkg::*;
#(
    parameter int SETTLE_CYC = 5000000,
    parameter int GATE_CYC   = 1000000,
    parameter int CNT_W      = 16,
    parameter int WHITE_TH   = 12000,
    parameter int BLACK_TH   = 300,
    parameter int CONTINUOUS = 1,
    parameter int HYST_N     = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             ip_signal_i,
    output logic             s2_o,
    output logic             s3_o,
    output logic [2:0]       color_o,
    output logic             color_vld_o,
    output logic [CNT_W-1:0] c_cnt_o,
    output logic [CNT_W-1:0] r_cnt_o,
    output logic [CNT_W-1:0] g_cnt_o,
    output logic [CNT_W-1:0] b_cnt_o,
    output logic             busy_o
);

    localparam int MAXC = (SETTLE_CYC > GATE_CYC) ? SETTLE_CYC : GATE_CYC;
    localparam int TW   = $clog2(MAXC + 1);
    localparam logic [TW-1:0] SET_LAST  = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] GATE_LAST = TW'(GATE_CYC - 1);

    state_e           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [1:0]       filter_q, filter_d;
    logic             busy_q, busy_d, vld_q, vld_d;
    logic [2:0]       color_q, color_d, cls;
    logic [CNT_W-1:0] c_q, c_d, r_q, r_d, g_q, g_d, b_q, b_d;
    logic [CNT_W-1:0] cnt_nxt, cnt_unused;
    logic             cnt_clr, cnt_en, early_exit, accept;

    sb_edge_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (cnt_clr),
        .en_i       (cnt_en),
        .sig_async_i(ip_signal_i),
        .cnt_o      (cnt_unused),
        .cnt_nxt_o  (cnt_nxt)
    );

    // Decided on the last CLEAR gate cycle, so use the value being latched
    assign early_exit = (32'(cnt_nxt) >= WHITE_TH) || (32'(cnt_nxt) < BLACK_TH);

    always_comb begin
        if (32'(c_q) >= WHITE_TH)            cls = COLOR_WHITE;
        else if (32'(c_q) < BLACK_TH)        cls = COLOR_NONE;
        else if (r_q >= g_q && r_q >= b_q)   cls = COLOR_RED;
        else if (g_q >= b_q)                 cls = COLOR_GREEN;
        else                                 cls = COLOR_BLUE;
    end

`ifdef SB_COLOR_HYST_EN
    localparam int HW = $clog2(HYST_N + 1);
    logic [2:0]    cand_q, cand_d;
    logic [HW-1:0] run_q, run_d;

    always_comb begin
        cand_d = cand_q;
        run_d  = run_q;
        accept = 1'b0;
        if (state_q == ST_CLASSIFY) begin
            if (cls == cand_q) begin
                if (run_q != HW'(HYST_N)) run_d = run_q + 1'b1;
            end else begin
                cand_d = cls;
                run_d  = HW'(1);
            end
            accept = (run_d == HW'(HYST_N));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cand_q <= COLOR_NONE;
            run_q  <= '0;
        end else begin
            cand_q <= cand_d;
            run_q  <= run_d;
        end
    end
`else
    logic hyst_unused;
    assign hyst_unused = (HYST_N != 0);
    assign accept      = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        filter_d = filter_q;
        busy_d   = busy_q;
        color_d  = color_q;
        vld_d    = 1'b0;
        c_d = c_q; r_d = r_q; g_d = g_q; b_d = b_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((CONTINUOUS != 0) || start_i) begin
                    state_d  = ST_SETTLE;
                    timer_d  = '0;
                    filter_d = F_CLEAR;
                    busy_d   = 1'b1;
                end
            end
            ST_SETTLE: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == SET_LAST) begin
                    state_d = ST_GATE;
                    timer_d = '0;
                    cnt_clr = 1'b1;
                end
            end
            ST_GATE: begin
                cnt_en  = 1'b1;
                timer_d = timer_q + 1'b1;
                if (timer_q == GATE_LAST) begin
                    timer_d = '0;
                    case (filter_q)
                        F_CLEAR: c_d = cnt_nxt;
                        F_RED:   r_d = cnt_nxt;
                        F_GREEN: g_d = cnt_nxt;
                        default: b_d = cnt_nxt;
                    endcase
                    if (filter_q == F_CLEAR && early_exit) begin
                        state_d = ST_CLASSIFY;
                    end else if (filter_q == F_BLUE) begin
                        state_d  = ST_CLASSIFY;
                        filter_d = F_CLEAR;
                    end else begin
                        state_d  = ST_SETTLE;
                        filter_d = filter_q + 2'd1;
                    end
                end
            end
            ST_CLASSIFY: begin
                // Outputs land together in UPDATE
                state_d  = ST_UPDATE;
                busy_d   = 1'b0;
                filter_d = F_CLEAR;
                if (accept) begin
                    color_d = cls;
                    vld_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            filter_q <= F_CLEAR;
            busy_q   <= 1'b0;
            vld_q    <= 1'b0;
            color_q  <= COLOR_NONE;
            c_q <= '0; r_q <= '0; g_q <= '0; b_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            filter_q <= filter_d;
            busy_q   <= busy_d;
            vld_q    <= vld_d;
            color_q  <= color_d;
            c_q <= c_d; r_q <= r_d; g_q <= g_d; b_q <= b_d;
        end
    end

    assign {s2_o, s3_o} = filter_sel(filter_q);
    assign color_o      = color_q;
    assign color_vld_o  = vld_q;
    assign busy_o       = busy_q;
    assign c_cnt_o      = c_q;
    assign r_cnt_o      = r_q;
    assign g_cnt_o      = g_q;
    assign b_cnt_o      = b_q;

endmodule

// File: tb/tb_sb_color_sensor_ctrl.sv
// Directed bench: main DUT plus a 4-bit-counter instance and a low-WHITE_TH
// instance sharing the same pins (white is unreachable with 100-cycle gates at TH=80).
module tb_sb_color_sensor_ctrl;

    localparam int S = 20, G = 100, SG = S + G;
    localparam int FULL = 4 * SG + 2, EARLY = SG + 2;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, ip = 1'b0;
    always #5 clk = ~clk;

    logic m_s2, m_s3, m_vld, m_busy; logic [2:0] m_col; logic [7:0] m_c, m_r, m_g, m_b;
    logic s_s2, s_s3, s_vld, s_busy; logic [2:0] s_col; logic [3:0] s_c, s_r, s_g, s_b;
    logic w_s2, w_s3, w_vld, w_busy; logic [2:0] w_col; logic [7:0] w_c, w_r, w_g, w_b;
    logic [2:0] vlds;
    assign vlds = {w_vld, s_vld, m_vld};

    sb_color_sensor_ctrl #(.SETTLE_CYC(S), .GATE_CYC(G), .CNT_W(8), .WHITE_TH(80),
        .BLACK_TH(5), .CONTINUOUS(0), .HYST_N(3)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ip_signal_i(ip), .s2_o(m_s2), .s3_o(m_s3),
        .color_o(m_col), .color_vld_o(m_vld), .c_cnt_o(m_c), .r_cnt_o(m_r), .g_cnt_o(m_g),
        .b_cnt_o(m_b), .busy_o(m_busy));

    sb_color_sensor_ctrl #(.SETTLE_CYC(S), .GATE_CYC(G), .CNT_W(4), .WHITE_TH(80),
        .BLACK_TH(5), .CONTINUOUS(0), .HYST_N(3)) dut_sat (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ip_signal_i(ip), .s2_o(s_s2), .s3_o(s_s3),
        .color_o(s_col), .color_vld_o(s_vld), .c_cnt_o(s_c), .r_cnt_o(s_r), .g_cnt_o(s_g),
        .b_cnt_o(s_b), .busy_o(s_busy));

    sb_color_sensor_ctrl #(.SETTLE_CYC(S), .GATE_CYC(G), .CNT_W(8), .WHITE_TH(40),
        .BLACK_TH(5), .CONTINUOUS(0), .HYST_N(3)) dut_wht (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ip_signal_i(ip), .s2_o(w_s2), .s3_o(w_s3),
        .color_o(w_col), .color_vld_o(w_vld), .c_cnt_o(w_c), .r_cnt_o(w_r), .g_cnt_o(w_g),
        .b_cnt_o(w_b), .busy_o(w_busy));

    int tests = 0, fails = 0;
    int vcyc [3];
    int vn [3];
    logic [1:0] sel_a, sel_b, sel_rst;
    logic       busy_rst;
    logic [2:0] col_rst;

    // Start pulse sampled at edge P0 (cycle 1); pulses for filter f rise just
    // before edge 120f+20+2j so the j-th edge is counted at 120f+22+2j.
    task automatic run_scan(input int nc, input int nr, input int ng, input int nb,
                            input int xs_k, input int rst_k, input int len);
        int n [4];
        n[0] = nc; n[1] = nr; n[2] = ng; n[3] = nb;
        for (int i = 0; i < 3; i++) begin vcyc[i] = 0; vn[i] = 0; end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < len; k++) begin
            logic hi;
            int kk;
            hi = 1'b0;
            for (int f = 0; f < 4; f++) begin
                int d;
                d = k - (SG * f + 19);
                if (d >= 0 && d < 2 * n[f] && (d % 2) == 0) hi = 1'b1;
            end
            ip    = hi;
            start = (k == xs_k);
            rst   = (k == rst_k);
            @(negedge clk);
            kk = k + 1;
            for (int i = 0; i < 3; i++)
                if (vlds[i]) begin vn[i]++; if (vcyc[i] == 0) vcyc[i] = kk + 1; end
            if (kk == SG - 1) sel_a = {m_s2, m_s3};
            if (kk == SG)     sel_b = {m_s2, m_s3};
            if (kk == rst_k + 1) begin sel_rst = {m_s2, m_s3}; busy_rst = m_busy; col_rst = m_col; end
        end
        ip = 1'b0; start = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if ({m_s2, m_s3} !== 2'b10) begin fails++; $display("FAIL reset_s2s3 got %b want 10", {m_s2, m_s3}); end
        tests++; if (m_col !== 3'b000) begin fails++; $display("FAIL reset_color got %b want 000", m_col); end
        tests++; if (m_vld !== 1'b0 || m_busy !== 1'b0) begin fails++; $display("FAIL reset_vld_busy got %b%b want 00", m_vld, m_busy); end
        tests++; if ({m_c, m_r, m_g, m_b} !== 32'h0) begin fails++; $display("FAIL reset_counts got %h want 0", {m_c, m_r, m_g, m_b}); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

`ifndef SB_COLOR_HYST_EN
    task automatic test_red_scan();
        run_scan(50, 40, 10, 10, -1, -1, FULL + 8);
        tests++; if (vcyc[0] !== FULL) begin fails++; $display("FAIL red_latency got %0d want %0d", vcyc[0], FULL); end
        tests++; if (vn[0] !== 1) begin fails++; $display("FAIL red_strobes got %0d want 1", vn[0]); end
        tests++; if (m_col !== 3'b100) begin fails++; $display("FAIL red_color got %b want 100", m_col); end
        tests++; if ({m_c, m_r, m_g, m_b} !== {8'd50, 8'd40, 8'd10, 8'd10}) begin fails++; $display("FAIL red_counts got %0d/%0d/%0d/%0d want 50/40/10/10", m_c, m_r, m_g, m_b); end
        tests++; if (m_busy !== 1'b0) begin fails++; $display("FAIL red_busy_after got %b want 0", m_busy); end
        tests++; if (sel_a !== 2'b10 || sel_b !== 2'b00) begin fails++; $display("FAIL red_filter_switch got %b,%b want 10,00", sel_a, sel_b); end
        tests++; if ({s_c, s_r, s_g, s_b} !== {4'd15, 4'd15, 4'd10, 4'd10}) begin fails++; $display("FAIL sat_counts got %0d/%0d/%0d/%0d want 15/15/10/10", s_c, s_r, s_g, s_b); end
        tests++; if (s_col !== 3'b100) begin fails++; $display("FAIL sat_color got %b want 100", s_col); end
        tests++; if (vcyc[2] !== EARLY || w_col !== 3'b111) begin fails++; $display("FAIL wht_first got %0d/%b want %0d/111", vcyc[2], w_col, EARLY); end
    endtask

    task automatic test_tie();
        run_scan(30, 30, 30, 20, 50, -1, FULL + 8);
        tests++; if (m_col !== 3'b100) begin fails++; $display("FAIL tie_rg color got %b want 100", m_col); end
        tests++; if (vn[0] !== 1 || vcyc[0] !== FULL) begin fails++; $display("FAIL busy_start_dropped got %0d@%0d want 1@%0d", vn[0], vcyc[0], FULL); end
        tests++; if (w_col !== 3'b100 || w_r !== 8'd30) begin fails++; $display("FAIL wht_full_scan got %b/%0d want 100/30", w_col, w_r); end
        run_scan(30, 20, 30, 30, -1, -1, FULL + 8);
        tests++; if (m_col !== 3'b010) begin fails++; $display("FAIL tie_gb color got %b want 010", m_col); end
        tests++; if (w_col !== 3'b010) begin fails++; $display("FAIL wht_tie_gb color got %b want 010", w_col); end
    endtask

    task automatic test_white();
        run_scan(50, 0, 0, 0, -1, -1, FULL + 8);
        tests++; if (vcyc[2] !== EARLY || vn[2] !== 1) begin fails++; $display("FAIL white_latency got %0d/%0d want %0d/1", vcyc[2], vn[2], EARLY); end
        tests++; if (w_col !== 3'b111) begin fails++; $display("FAIL white_color got %b want 111", w_col); end
        tests++; if ({w_r, w_g, w_b} !== {8'd20, 8'd30, 8'd30}) begin fails++; $display("FAIL white_rgb_kept got %0d/%0d/%0d want 20/30/30", w_r, w_g, w_b); end
        tests++; if ({w_s2, w_s3} !== 2'b10 || w_busy !== 1'b0) begin fails++; $display("FAIL white_exit got %b/%b want 10/0", {w_s2, w_s3}, w_busy); end
        tests++; if (m_col !== 3'b100 || m_r !== 8'd0) begin fails++; $display("FAIL zero_rgb_tie got %b/%0d want 100/0", m_col, m_r); end
    endtask

    task automatic test_black();
        run_scan(0, 0, 0, 0, -1, -1, EARLY + 10);
        tests++; if (vcyc[0] !== EARLY || vn[0] !== 1) begin fails++; $display("FAIL black_latency got %0d/%0d want %0d/1", vcyc[0], vn[0], EARLY); end
        tests++; if (m_col !== 3'b000 || m_c !== 8'd0) begin fails++; $display("FAIL black_color got %b/%0d want 000/0", m_col, m_c); end
        tests++; if (m_busy !== 1'b0) begin fails++; $display("FAIL black_busy got %b want 0", m_busy); end
    endtask

    task automatic test_rst_mid_scan();
        run_scan(50, 40, 40, 40, -1, 2 * SG + 50, FULL + 8);
        tests++; if (sel_rst !== 2'b10 || busy_rst !== 1'b0) begin fails++; $display("FAIL rst_mid got %b/%b want 10/0", sel_rst, busy_rst); end
        tests++; if (col_rst !== 3'b000) begin fails++; $display("FAIL rst_mid_color got %b want 000", col_rst); end
        tests++; if (vn[0] !== 0) begin fails++; $display("FAIL rst_mid_strobe got %0d want 0", vn[0]); end
        tests++; if (m_r !== 8'd0 || m_busy !== 1'b0) begin fails++; $display("FAIL rst_mid_after got %0d/%b want 0/0", m_r, m_busy); end
    endtask
`else
    task automatic test_hyst();
        for (int s = 1; s <= 3; s++) begin
            run_scan(50, 40, 10, 10, -1, -1, FULL + 8);
            tests++; if (vn[0] !== (s == 3 ? 1 : 0)) begin fails++; $display("FAIL hyst_scan%0d strobes got %0d want %0d", s, vn[0], (s == 3 ? 1 : 0)); end
            tests++; if (m_busy !== 1'b0) begin fails++; $display("FAIL hyst_scan%0d busy got %b want 0", s, m_busy); end
        end
        tests++; if (m_col !== 3'b100) begin fails++; $display("FAIL hyst_color got %b want 100", m_col); end
    endtask
`endif

    initial begin
        test_reset();
`ifndef SB_COLOR_HYST_EN
        test_red_scan();
        test_tie();
        test_white();
        test_black();
        test_rst_mid_scan();
`else
        test_hyst();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
